// File: rtl/apb_master_nslave.sv
// apb_master_nslave
// -----------------
// APB3 master and address decoder. It bridges the CPU simple bus
// (transfer/ready/write/addr/wdata/rdata) to NUM_SLAVES APB peripherals.
// Each peripheral owns one 2**SLOT_BITS byte slot, starting at BASE_ADDR.
// The bridge reports an error for unmapped addresses and for slaves whose
// PREADY does not arrive within TIMEOUT_CYCLES ACCESS cycles.
//
// Optional build macro: APB_PSLVERR_EN
//   When defined, the PSLVERR input is added and is returned on err at
//   completion.
//
// Ports:
//   PCLK      in   clock; every flop updates on its rising edge
//   PRESET    in   synchronous, active-high reset
//   transfer  in   one-cycle request strobe from the CPU
//   write     in   1 = write, 0 = read; sampled with transfer
//   addr      in   byte address; sampled with transfer
//   wdata     in   write data; sampled with transfer
//   rdata     out  read data; valid while ready=1, held until next completion
//   ready     out  one-cycle completion pulse
//   err       out  error flag; valid while ready=1
//   PADDR     out  APB address
//   PWRITE    out  APB write
//   PENABLE   out  APB enable
//   PWDATA    out  APB write data
//   PSEL      out  one-hot slave select
//   PRDATA    in   packed read data; slot i occupies [i*DATA_W +: DATA_W]
//   PREADY    in   per-slave ready
//   PSLVERR   in   per-slave error (APB_PSLVERR_EN only)
//
// States:
//   IDLE   | waiting for transfer; completion/error pulses are issued here
//   SETUP  | PSEL asserted, PENABLE low, exactly one cycle
//   ACCESS | PSEL and PENABLE asserted; wait for PREADY or timeout

module apb_master_nslave #(
    parameter int                NUM_SLAVES     = 8,
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = 32'h1000_0000,
    parameter int                SLOT_BITS      = 12,
    parameter int                TIMEOUT_CYCLES = 255
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic                         transfer,
    input  logic                         write,
    input  logic [ADDR_W-1:0]            addr,
    input  logic [DATA_W-1:0]            wdata,
    output logic [DATA_W-1:0]            rdata,
    output logic                         ready,
    output logic                         err,
    output logic [ADDR_W-1:0]            PADDR,
    output logic                         PWRITE,
    output logic                         PENABLE,
    output logic [DATA_W-1:0]            PWDATA,
    output logic [NUM_SLAVES-1:0]        PSEL,
    input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
`ifdef APB_PSLVERR_EN
    input  logic [NUM_SLAVES-1:0]        PREADY,
    input  logic [NUM_SLAVES-1:0]        PSLVERR
`else
    input  logic [NUM_SLAVES-1:0]        PREADY
`endif
);

    localparam int IDX_W     = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    // A zero-width counter is illegal. Keep one bit when the timeout is disabled.
    localparam int CNT_W     = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int TO_LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [ADDR_W-1:0]   r_paddr;
    logic [DATA_W-1:0]   r_pwdata;
    logic                r_pwrite;
    logic [IDX_W-1:0]    r_sel_idx;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_ready;
    logic                r_err;

    logic [ADDR_W-1:0]   w_off;
    logic [ADDR_W-1:0]   w_idx;
    logic                w_mapped;
    logic                w_sel_ready;
    logic                w_sel_slverr;
    logic [DATA_W-1:0]   w_sel_rdata;
    logic                w_timeout;

    // Address decode. The unsigned lower-bound check rejects addresses
    // below BASE_ADDR that would otherwise wrap into a valid slot index.
    assign w_off    = addr - BASE_ADDR;
    assign w_idx    = w_off >> SLOT_BITS;
    assign w_mapped = (addr >= BASE_ADDR) && (w_idx < ADDR_W'(NUM_SLAVES));

    // Only the selected slave's response is observed.
    assign w_sel_ready = PREADY[r_sel_idx];
    assign w_sel_rdata = PRDATA[int'(r_sel_idx) * DATA_W +: DATA_W];
`ifdef APB_PSLVERR_EN
    assign w_sel_slverr = PSLVERR[r_sel_idx];
`else
    assign w_sel_slverr = 1'b0;
`endif

    // r_cnt holds the number of ACCESS cycles already completed. The edge
    // that ends ACCESS cycle number TIMEOUT_CYCLES aborts the transfer,
    // unless PREADY is high on that same edge.
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST) && !w_sel_ready;

    // State register
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (transfer && w_mapped) begin
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (w_sel_ready || w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // APB control outputs, decoded from the state
    always_comb begin
        PSEL    = '0;
        PENABLE = 1'b0;
        case (r_state)
            ST_SETUP: begin
                PSEL[r_sel_idx] = 1'b1;
            end
            ST_ACCESS: begin
                PSEL[r_sel_idx] = 1'b1;
                PENABLE         = 1'b1;
            end
            default: begin
                PSEL    = '0;
                PENABLE = 1'b0;
            end
        endcase
    end

    // Request capture, wait counter and completion/error pulses
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pwrite  <= 1'b0;
            r_sel_idx <= '0;
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (transfer) begin
                        if (w_mapped) begin
                            r_paddr   <= addr;
                            r_pwdata  <= wdata;
                            r_pwrite  <= write;
                            r_sel_idx <= w_idx[IDX_W-1:0];
                            r_cnt     <= '0;
                        end else begin
                            r_ready <= 1'b1;
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (w_sel_ready) begin
                        r_ready <= 1'b1;
                        r_err   <= w_sel_slverr;
                        r_rdata <= w_sel_rdata;
                    end else if (w_timeout) begin
                        r_ready <= 1'b1;
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign PADDR  = r_paddr;
    assign PWDATA = r_pwdata;
    assign PWRITE = r_pwrite;
    assign rdata  = r_rdata;
    assign ready  = r_ready;
    assign err    = r_err;

endmodule

// File: tb/tb_apb_master_nslave.sv
// Testbench for apb_master_nslave: eight slots and a timeout of four
// ACCESS cycles.
// A behavioural slave farm answers after a per-slot latency. A latency of 0
// means the slave never answers. Expected completions go into a scoreboard
// queue and are compared when ready pulses.

module tb_apb_master_nslave;

    localparam int NS = 8;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 4;

    logic              clk;
    logic              rst;
    logic              transfer;
    logic              write;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     wdata;
    logic [DW-1:0]     rdata;
    logic              ready;
    logic              err;
    logic [AW-1:0]     paddr;
    logic              pwrite;
    logic              penable;
    logic [DW-1:0]     pwdata;
    logic [NS-1:0]     psel;
    logic [NS*DW-1:0]  prdata;
    logic [NS-1:0]     pready;
`ifdef APB_PSLVERR_EN
    logic [NS-1:0]     pslverr;
`endif

    apb_master_nslave #(
        .NUM_SLAVES     (NS),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .BASE_ADDR      (32'h1000_0000),
        .SLOT_BITS      (12),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .PCLK     (clk),
        .PRESET   (rst),
        .transfer (transfer),
        .write    (write),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .err      (err),
        .PADDR    (paddr),
        .PWRITE   (pwrite),
        .PENABLE  (penable),
        .PWDATA   (pwdata),
        .PSEL     (psel),
        .PRDATA   (prdata),
`ifdef APB_PSLVERR_EN
        .PREADY   (pready),
        .PSLVERR  (pslverr)
`else
        .PREADY   (pready)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- slave farm ----------------
    logic [DW-1:0] slot_data [NS];
    int            lat [NS];
    int            acc_cnt;

    always_comb begin
        prdata = '0;
        pready = '0;
        for (int i = 0; i < NS; i++) begin
            prdata[i*DW +: DW] = slot_data[i];
            pready[i] = psel[i] && penable && (lat[i] != 0) && (acc_cnt + 1 == lat[i]);
        end
    end

    always @(posedge clk) begin
        if (penable && (psel != '0) && ((psel & pready) == '0))
            acc_cnt <= acc_cnt + 1;
        else
            acc_cnt <= 0;
    end

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    endtask

    typedef struct {
        logic          err;
        logic          chk_rd;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t sb[$];

    logic [AW-1:0] exp_paddr;
    logic [DW-1:0] exp_pwdata;
    logic          exp_pwrite;
    logic [NS-1:0] exp_psel;

    logic [NS-1:0] prev_psel;
    logic          prev_penable;
    logic [AW-1:0] prev_paddr;
    logic [DW-1:0] prev_pwdata;
    logic          prev_pwrite;

    // Scoreboard and protocol monitor, sampled on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_ready", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("err", err, e.err);
                    if (e.chk_rd) chk("rdata", rdata, e.rdata);
                end
            end
            if (err && !ready) chk("err_without_ready", 1, 0);
            if (psel != '0 && !penable) begin
                chk("setup_psel", psel, exp_psel);
                chk("setup_paddr", paddr, exp_paddr);
                chk("setup_pwrite", pwrite, exp_pwrite);
                if (exp_pwrite) chk("setup_pwdata", pwdata, exp_pwdata);
            end
            if (penable) chk("enable_after_setup", prev_psel, psel);
            if (psel != '0 && prev_psel != '0) begin
                chk("paddr_stable", paddr, prev_paddr);
                chk("pwdata_stable", pwdata, prev_pwdata);
                chk("pwrite_stable", pwrite, prev_pwrite);
            end
        end
        prev_psel    = psel;
        prev_penable = penable;
        prev_paddr   = paddr;
        prev_pwdata  = pwdata;
        prev_pwrite  = pwrite;
    end

    // ---------------- stimulus ----------------
    function automatic logic [NS-1:0] onehot_of(input logic [AW-1:0] a);
        logic [AW-1:0] idx;
        logic [NS-1:0] v;
        idx = (a - 32'h1000_0000) >> 12;
        v = '0;
        if (a >= 32'h1000_0000 && idx < AW'(NS)) v[idx[2:0]] = 1'b1;
        return v;
    endfunction

    // Called right after a falling edge. The task drives a transfer, pushes
    // its expected result, waits for ready and then checks the latency.
    // A latency of 1 means ready arrives in the cycle after the request.
    // glitch_at > 0 pulses an extra transfer at that falling edge, which the
    // DUT must ignore.
    task automatic run_xfer(input string tag, input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input int exp_lat, input logic exp_err,
                            input logic chk_rd, input logic [DW-1:0] exp_rd, input int glitch_at);
        exp_t e;
        int   n;
        e.err = exp_err; e.chk_rd = chk_rd; e.rdata = exp_rd;
        sb.push_back(e);
        exp_paddr  = a;
        exp_pwdata = wd;
        exp_pwrite = wr;
        exp_psel   = onehot_of(a);
        transfer = 1'b1; write = wr; addr = a; wdata = wd;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            transfer = 1'b0;
            if (glitch_at != 0 && n == glitch_at) begin
                transfer = 1'b1; write = 1'b0; addr = 32'h1000_0000;
            end
            if (ready) break;
        end
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_psel_in_ready"}, psel, '0);
        chk({tag, "_penable_in_ready"}, penable, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0;
`ifdef APB_PSLVERR_EN
        pslverr = '0;
`endif
        for (int i = 0; i < NS; i++) begin
            slot_data[i] = 32'hD000_0000 + 32'(i);
            lat[i] = 1;
        end
        slot_data[2] = 32'hCAFE_0001;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_pwrite", pwrite, 0);
        rst = 1'b0;
        @(negedge clk);

        // minimum-latency read from slot 2
        run_xfer("rd_slot2", 1'b0, 32'h1000_2004, '0, 3, 1'b0, 1'b1, 32'hCAFE_0001, 0);
        @(negedge clk);

        // write to slot 1 that waits 3 ACCESS cycles
        lat[1] = 3;
        run_xfer("wr_slot1", 1'b1, 32'h1000_1010, 32'h0000_00A5, 5, 1'b0, 1'b0, '0, 0);
        @(negedge clk);

        // unmapped addresses above and below the window
        run_xfer("unmap_hi", 1'b0, 32'h1000_8000, '0, 1, 1'b1, 1'b1, 32'h0, 0);
        run_xfer("unmap_lo", 1'b0, 32'h0FFF_FFFC, '0, 1, 1'b1, 1'b1, 32'h0, 0);

        // last byte-word of the last slot, which is still mapped
        lat[7] = 2;
        run_xfer("last_slot", 1'b0, 32'h1000_7FFC, '0, 4, 1'b0, 1'b1, 32'hD000_0007, 0);
        @(negedge clk);

        // slot 3 never answers -> abort after 4 ACCESS cycles
        lat[3] = 0;
        run_xfer("timeout", 1'b0, 32'h1000_3000, '0, 6, 1'b1, 1'b1, 32'h0, 0);
        @(negedge clk);
        // PREADY on the 4th ACCESS cycle wins over the timeout
        lat[3] = 4;
        run_xfer("ready_at_limit", 1'b0, 32'h1000_3008, '0, 6, 1'b0, 1'b1, 32'hD000_0003, 0);

        // back-to-back: the next request is issued in the ready cycle
        run_xfer("b2b_a", 1'b0, 32'h1000_2000, '0, 3, 1'b0, 1'b1, 32'hCAFE_0001, 0);
        run_xfer("b2b_b", 1'b0, 32'h1000_0004, '0, 3, 1'b0, 1'b1, 32'hD000_0000, 0);
        @(negedge clk);

        // a transfer pulse during ACCESS must be ignored
        run_xfer("ignore", 1'b1, 32'h1000_1020, 32'h1234_5678, 5, 1'b0, 1'b0, '0, 2);
        repeat (6) @(negedge clk);
        chk("ignore_no_extra", 32'(sb.size()), 0);

        // reset while in ACCESS drops the transfer
        lat[3] = 0;
        exp_paddr = 32'h1000_3010; exp_pwdata = '0; exp_pwrite = 1'b0;
        exp_psel = onehot_of(32'h1000_3010);
        transfer = 1'b1; write = 1'b0; addr = 32'h1000_3010;
        @(negedge clk); transfer = 1'b0;
        @(negedge clk);
        chk("pre_rst_penable", penable, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_psel", psel, 0);
        chk("midrst_penable", penable, 0);
        chk("midrst_ready", ready, 0);
        chk("midrst_err", err, 0);
        chk("midrst_paddr", paddr, 0);
        chk("midrst_rdata", rdata, 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        lat[3] = 1;
        run_xfer("after_rst", 1'b0, 32'h1000_3000, '0, 3, 1'b0, 1'b1, 32'hD000_0003, 0);
        @(negedge clk);

`ifdef APB_PSLVERR_EN
        pslverr[0] = 1'b1;
        run_xfer("pslverr", 1'b0, 32'h1000_0000, '0, 3, 1'b1, 1'b1, 32'hD000_0000, 0);
        pslverr[0] = 1'b0;
        @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
